// File: rtl/cpu_mc.sv
// Multi-cycle accumulator-free load/store CPU: FETCH/DECODE/EXEC/MEM/WB, one state per cycle,
// with instruction and data memory stall handshakes.
module cpu_mc #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int PC_W   = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic [PC_W-1:0]   PC,
  input  logic [31:0]       INSTRUCTION,
  input  logic              IBUSYWAIT,
  output logic [DATA_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] WRITEDATA,
  input  logic [DATA_W-1:0] READDATA,
  output logic              READ,
  output logic              WRITE,
  input  logic              DBUSYWAIT,
  output logic              RETIRE,
  output logic              ILLEGAL
);

  localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_e;

  typedef enum logic [7:0] {
    OP_LOADI = 8'h00,
    OP_MOV   = 8'h01,
    OP_ADD   = 8'h02,
    OP_SUB   = 8'h03,
    OP_AND   = 8'h04,
    OP_OR    = 8'h05,
    OP_J     = 8'h06,
    OP_BEQ   = 8'h07,
    OP_BNE   = 8'h0D,
    OP_LWD   = 8'h0E,
    OP_LWI   = 8'h0F,
    OP_SWD   = 8'h10,
    OP_SWI   = 8'h11
  } op_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              retire_q, retire_d;
  logic              illegal_q, illegal_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic              rf_we;

  op_e               op;
  logic [RW-1:0]     rd_idx, rt_idx, rs_idx;
  logic [DATA_W-1:0] imm2;
  logic [PC_W-1:0]   pc_inc, br_tgt;
  logic              is_store;
  logic              unused_fields;

  assign op       = op_e'(ir_q[31:24]);
  assign rd_idx   = ir_q[16 +: RW];
  assign rt_idx   = ir_q[8 +: RW];
  assign rs_idx   = ir_q[0 +: RW];
  assign imm2     = DATA_W'($signed(ir_q[7:0]));
  assign pc_inc   = pc_q + PC_W'(4);
  assign br_tgt   = pc_inc + PC_W'($signed({ir_q[23:16], 2'b00}));
  assign is_store = (op == OP_SWD) || (op == OP_SWI);
  assign unused_fields = ^ir_q[15:8];

  // Stores source their data from the RD field, so operand A switches register on opcode.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    res_d     = res_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    read_d    = read_q;
    write_d   = write_q;
    retire_d  = 1'b0;
    illegal_d = 1'b0;
    rf_we     = 1'b0;
    case (state_q)
      FETCH: begin
        if (!IBUSYWAIT) begin
          ir_d    = INSTRUCTION;
          state_d = DECODE;
        end
      end
      DECODE: begin
        opa_d   = is_store ? regs_q[rd_idx] : regs_q[rt_idx];
        opb_d   = regs_q[rs_idx];
        state_d = EXEC;
      end
      EXEC: begin
        state_d = WB;
        case (op)
          OP_LOADI: res_d = imm2;
          OP_MOV:   res_d = opb_q;
          OP_ADD:   res_d = opa_q + opb_q;
          OP_SUB:   res_d = opa_q - opb_q;
          OP_AND:   res_d = opa_q & opb_q;
          OP_OR:    res_d = opa_q | opb_q;
          OP_J: begin
            pc_d     = br_tgt;
            retire_d = 1'b1;
            state_d  = FETCH;
          end
          OP_BEQ: begin
            pc_d     = (opa_q == opb_q) ? br_tgt : pc_inc;
            retire_d = 1'b1;
            state_d  = FETCH;
          end
          OP_BNE: begin
            pc_d     = (opa_q != opb_q) ? br_tgt : pc_inc;
            retire_d = 1'b1;
            state_d  = FETCH;
          end
          OP_LWD: begin
            addr_d  = opb_q;
            read_d  = 1'b1;
            state_d = MEM;
          end
          OP_LWI: begin
            addr_d  = imm2;
            read_d  = 1'b1;
            state_d = MEM;
          end
          OP_SWD: begin
            addr_d  = opb_q;
            wdata_d = opa_q;
            write_d = 1'b1;
            state_d = MEM;
          end
          OP_SWI: begin
            addr_d  = imm2;
            wdata_d = opa_q;
            write_d = 1'b1;
            state_d = MEM;
          end
          default: begin
            pc_d      = pc_inc;
            retire_d  = 1'b1;
            illegal_d = 1'b1;
            state_d   = FETCH;
          end
        endcase
      end
      MEM: begin
        if (!DBUSYWAIT) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (read_q) begin
            res_d   = READDATA;
            state_d = WB;
          end else begin
            pc_d     = pc_inc;
            retire_d = 1'b1;
            state_d  = FETCH;
          end
        end
      end
      WB: begin
        rf_we    = 1'b1;
        pc_d     = pc_inc;
        retire_d = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      retire_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      res_q     <= res_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      read_q    <= read_d;
      write_q   <= write_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rd_idx] <= res_q;
    end
  end

  assign PC        = pc_q;
  assign ADDRESS   = addr_q;
  assign WRITEDATA = wdata_q;
  assign READ      = read_q;
  assign WRITE     = write_q;
  assign RETIRE    = retire_q;
  assign ILLEGAL   = illegal_q;

endmodule

// File: tb/tb_cpu_mc.sv
// Scoreboard bench for cpu_mc: an ISA-level model pre-computes retirements and memory
// transactions per program; a negedge monitor pops and compares them as the DUT produces them.
module tb_cpu_mc;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int PW = 32;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic [PW-1:0] PC;
  logic [31:0]   INSTRUCTION;
  logic          IBUSYWAIT = 1'b0;
  logic [DW-1:0] ADDRESS, WRITEDATA, READDATA;
  logic          READ, WRITE, DBUSYWAIT, RETIRE, ILLEGAL;

  cpu_mc #(.DATA_W(DW), .NREGS(NR), .PC_W(PW)) dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION), .IBUSYWAIT(IBUSYWAIT),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA), .READ(READ), .WRITE(WRITE),
    .DBUSYWAIT(DBUSYWAIT), .RETIRE(RETIRE), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [PW-1:0] pc; bit ill; int lat; } ret_t;
  typedef struct { logic [DW-1:0] addr; logic [DW-1:0] data; bit wr; int cyc; } mem_t;

  ret_t rq[$];
  mem_t mq[$];

  logic [31:0]   imem  [64];
  logic [DW-1:0] dmem  [256];
  logic [DW-1:0] mdmem [256];
  logic [DW-1:0] mreg  [NR];
  logic [PW-1:0] mpc;

  int n_chk = 0, n_fail = 0;
  int dlat = 0, dcnt = 0, cnt = 0, last = 0, scyc = 0;
  bit istall = 1'b0;
  logic [PW-1:0] cur_pc = '0;
  mem_t cur;
  ret_t r;

  assign INSTRUCTION = imem[PC[7:2]];
  assign READDATA    = dmem[ADDRESS[7:0]];
  assign DBUSYWAIT   = (READ || WRITE) && (dcnt < dlat);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory and cycle-count bookkeeping.
  always @(posedge CLK) begin
    if ((READ || WRITE) && DBUSYWAIT) dcnt <= dcnt + 1;
    else dcnt <= 0;
    if (WRITE && !DBUSYWAIT) dmem[ADDRESS[7:0]] <= WRITEDATA;
    cnt <= RESET ? cnt + 1 : 0;
  end

  always begin
    @(posedge CLK);
    #1;
    IBUSYWAIT = istall ? ($urandom_range(0, 2) == 0) : 1'b0;
  end

  always @(negedge CLK) begin
    if (!RESET) begin
      scyc   = 0;
      last   = 0;
      cur_pc = '0;
    end else begin
      if (RETIRE) begin
        if (rq.size() == 0) check("retire_unexpected", RETIRE, 0);
        else begin
          r = rq.pop_front();
          cur_pc = r.pc;
          check("ret_illegal", ILLEGAL, r.ill);
          if (r.lat != 0) check("ret_latency", cnt - last, r.lat);
        end
        last = cnt;
      end else if (ILLEGAL) begin
        check("illegal_without_retire", ILLEGAL, 0);
      end
      check("pc", PC, cur_pc);
      if (READ || WRITE) begin
        scyc++;
        if (scyc == 1) begin
          check("rw_exclusive", READ && WRITE, 0);
          if (mq.size() == 0) begin
            check("mem_unexpected", {READ, WRITE}, 0);
            cur = '{addr: 'x, data: 'x, wr: 1'b0, cyc: 0};
          end else cur = mq.pop_front();
        end
        check("mem_is_write", WRITE, cur.wr);
        check("mem_addr", ADDRESS, cur.addr);
        if (cur.wr) check("mem_wdata", WRITEDATA, cur.data);
        if (!DBUSYWAIT) begin
          check("strobe_cycles", scyc, cur.cyc);
          scyc = 0;
        end
      end
    end
  end

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] c);
    return {op, a, b, c};
  endfunction

  function automatic logic [DW-1:0] sx(input logic [7:0] v);
    return {{(DW-8){v[7]}}, v};
  endfunction

  task automatic model_reset();
    mpc = '0;
    for (int i = 0; i < NR; i++) mreg[i] = '0;
  endtask

  task automatic model_step(input bit zw);
    logic [31:0] w;
    int rd, rt, rs, lat;
    logic [DW-1:0] i2;
    logic [PW-1:0] nx, tgt;
    ret_t e;
    mem_t m;
    w   = imem[mpc[7:2]];
    rd  = int'(w[23:16]) % NR;
    rt  = int'(w[15:8]) % NR;
    rs  = int'(w[7:0]) % NR;
    i2  = sx(w[7:0]);
    nx  = mpc + 4;
    tgt = mpc + 4 + {{(PW-10){w[23]}}, w[23:16], 2'b00};
    e.ill = 1'b0;
    lat = 4;
    case (w[31:24])
      8'h00: mreg[rd] = i2;
      8'h01: mreg[rd] = mreg[rs];
      8'h02: mreg[rd] = mreg[rt] + mreg[rs];
      8'h03: mreg[rd] = mreg[rt] - mreg[rs];
      8'h04: mreg[rd] = mreg[rt] & mreg[rs];
      8'h05: mreg[rd] = mreg[rt] | mreg[rs];
      8'h06: begin nx = tgt; lat = 3; end
      8'h07: begin if (mreg[rt] == mreg[rs]) nx = tgt; lat = 3; end
      8'h0D: begin if (mreg[rt] != mreg[rs]) nx = tgt; lat = 3; end
      8'h0E, 8'h0F: begin
        m = '{addr: (w[24] ? i2 : mreg[rs]), data: '0, wr: 1'b0, cyc: dlat + 1};
        mq.push_back(m);
        mreg[rd] = mdmem[m.addr[7:0]];
        lat = 5;
      end
      8'h10, 8'h11: begin
        m = '{addr: (w[24] ? i2 : mreg[rs]), data: mreg[rd], wr: 1'b1, cyc: dlat + 1};
        mq.push_back(m);
        mdmem[m.addr[7:0]] = mreg[rd];
      end
      default: begin e.ill = 1'b1; lat = 3; end
    endcase
    mpc   = nx;
    e.pc  = nx;
    e.lat = zw ? lat : 0;
    rq.push_back(e);
  endtask

  task automatic model_run(input int n, input bit zw);
    for (int i = 0; i < n; i++) model_step(zw);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) imem[i] = '0;
    for (int i = 0; i < 256; i++) begin dmem[i] = '0; mdmem[i] = '0; end
  endtask

  task automatic reset_assert();
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(posedge CLK);
    #1;
    check("rst_pc", PC, 0);
    check("rst_read", READ, 0);
    check("rst_write", WRITE, 0);
    check("rst_retire", RETIRE, 0);
    check("rst_illegal", ILLEGAL, 0);
    check("rst_address", ADDRESS, 0);
    check("rst_writedata", WRITEDATA, 0);
    rq.delete();
    mq.delete();
  endtask

  task automatic reset_release();
    RESET = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (rq.size() == 0) break;
      @(posedge CLK);
      #1;
    end
    check("drain_retires_left", rq.size(), 0);
    check("drain_mem_left", mq.size(), 0);
  endtask

  initial begin
    // Zero-wait arithmetic, store, jump: latencies and PC after 12 cycles.
    reset_assert();
    clear_mem();
    imem[0] = ins(8'h00, 8'h01, 8'h00, 8'h05);
    imem[1] = ins(8'h00, 8'h02, 8'h00, 8'hFD);
    imem[2] = ins(8'h02, 8'h03, 8'h01, 8'h02);
    imem[3] = ins(8'h11, 8'h03, 8'h00, 8'h20);
    imem[4] = ins(8'h06, 8'hFF, 8'h00, 8'h00);
    dlat = 0; istall = 1'b0;
    model_reset();
    model_run(5, 1'b1);
    reset_release();
    repeat (12) @(posedge CLK);
    #1 check("pc_after_12_cycles", PC, 32'h0C);
    drain(200);

    // Stalled memories, SUB wrap, logic ops, loads, register index aliasing, branches.
    reset_assert();
    clear_mem();
    imem[0]  = ins(8'h00, 8'h09, 8'h00, 8'h7F);
    imem[1]  = ins(8'h03, 8'h02, 8'h00, 8'h01);
    imem[2]  = ins(8'h11, 8'h02, 8'h00, 8'h21);
    imem[3]  = ins(8'h04, 8'h04, 8'h02, 8'h01);
    imem[4]  = ins(8'h05, 8'h05, 8'h02, 8'h01);
    imem[5]  = ins(8'h01, 8'h06, 8'h00, 8'h05);
    imem[6]  = ins(8'h10, 8'h06, 8'h00, 8'h01);
    imem[7]  = ins(8'h0F, 8'h07, 8'h00, 8'h21);
    imem[8]  = ins(8'h0E, 8'h03, 8'h00, 8'h01);
    imem[9]  = ins(8'h11, 8'h07, 8'h00, 8'h22);
    imem[10] = ins(8'h11, 8'h03, 8'h00, 8'h23);
    imem[11] = ins(8'h11, 8'h04, 8'h00, 8'h24);
    imem[12] = ins(8'h0D, 8'h01, 8'h01, 8'h02);
    imem[13] = ins(8'h00, 8'h04, 8'h00, 8'h55);
    imem[14] = ins(8'h07, 8'h03, 8'h01, 8'h02);
    imem[15] = ins(8'h11, 8'h04, 8'h00, 8'h25);
    imem[16] = ins(8'h06, 8'hFF, 8'h00, 8'h00);
    dlat = 2; istall = 1'b1;
    model_reset();
    model_run(16, 1'b0);
    reset_release();
    drain(2000);
    istall = 1'b0;

    // BEQ taken backwards from 0x10 to 0x0C, with a 3-cycle store stall in the loop.
    reset_assert();
    clear_mem();
    imem[0] = ins(8'h00, 8'h01, 8'h00, 8'h03);
    imem[1] = ins(8'h00, 8'h02, 8'h00, 8'h03);
    imem[2] = ins(8'h00, 8'h04, 8'h00, 8'h09);
    imem[3] = ins(8'h11, 8'h04, 8'h00, 8'h20);
    imem[4] = ins(8'h07, 8'hFE, 8'h01, 8'h02);
    dlat = 3;
    model_reset();
    model_run(7, 1'b0);
    reset_release();
    drain(500);

    // BNE not taken, undefined opcode, registers preserved across it.
    reset_assert();
    clear_mem();
    imem[0] = ins(8'h00, 8'h01, 8'h00, 8'h03);
    imem[1] = ins(8'h00, 8'h02, 8'h00, 8'h03);
    imem[2] = ins(8'h00, 8'h04, 8'h00, 8'h09);
    imem[3] = ins(8'h11, 8'h04, 8'h00, 8'h30);
    imem[4] = ins(8'h0D, 8'hFE, 8'h01, 8'h02);
    imem[5] = ins(8'h3F, 8'h01, 8'h00, 8'h07);
    imem[6] = ins(8'h11, 8'h01, 8'h00, 8'h31);
    imem[7] = ins(8'h06, 8'hFF, 8'h00, 8'h00);
    dlat = 0;
    model_reset();
    model_run(8, 1'b1);
    reset_release();
    drain(300);

    // Reset while a load is stalled, then prove the destination register stayed zero.
    reset_assert();
    clear_mem();
    dmem[8'h40] = 16'h1234;
    mdmem[8'h40] = 16'h1234;
    imem[0] = ins(8'h00, 8'h01, 8'h00, 8'h40);
    imem[1] = ins(8'h0E, 8'h03, 8'h00, 8'h01);
    imem[2] = ins(8'h06, 8'hFF, 8'h00, 8'h00);
    dlat = 20;
    model_reset();
    model_run(2, 1'b0);
    void'(rq.pop_back());
    reset_release();
    for (int i = 0; i < 100 && !READ; i++) begin
      @(posedge CLK);
      #1;
    end
    check("load_started", READ, 1);
    repeat (2) @(posedge CLK);
    reset_assert();
    imem[1] = ins(8'h11, 8'h03, 8'h00, 8'h41);
    imem[2] = ins(8'h06, 8'hFF, 8'h00, 8'h00);
    dlat = 0;
    model_reset();
    model_run(3, 1'b1);
    reset_release();
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit, %0d failures so far", n_fail);
    $fatal(1, "timeout");
  end

endmodule
